// File: rtl/instr_fetch_loader_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_loader_if
//   Bundles the program-load handshake and the core-side fetch bus of the
//   instruction fetch loader.
//
//   master : the side that loads the program and runs the core
//            (drives LOAD_EN, HALT_REQ, DIN, DIN_VALID, PC)
//   slave  : the loader itself
//            (drives DIN_READY, INSTRUCTION, INSTR_VALID, CPU_EN, LOAD_COUNT)
//
//   LOAD_EN      1 = request/continue program load
//   HALT_REQ     1 = freeze instruction delivery while running
//   DIN          program byte
//   DIN_VALID    DIN holds a byte to store
//   DIN_READY    loader accepts DIN this cycle
//   PC           core program counter (byte address, 8 bits)
//   INSTRUCTION  fetched instruction, registered
//   INSTR_VALID  INSTRUCTION holds a loaded entry
//   CPU_EN       core may advance (RUN state only)
//   LOAD_COUNT   bytes stored in the current program (AW+1 bits)
// ---------------------------------------------------------------------------
interface instr_fetch_loader_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic          LOAD_EN;
  logic          HALT_REQ;
  logic [DW-1:0] DIN;
  logic          DIN_VALID;
  logic          DIN_READY;
  logic [7:0]    PC;
  logic [DW-1:0] INSTRUCTION;
  logic          INSTR_VALID;
  logic          CPU_EN;
  logic [AW:0]   LOAD_COUNT;

  modport master (
    output LOAD_EN, HALT_REQ, DIN, DIN_VALID, PC,
    input  DIN_READY, INSTRUCTION, INSTR_VALID, CPU_EN, LOAD_COUNT
  );

  modport slave (
    input  LOAD_EN, HALT_REQ, DIN, DIN_VALID, PC,
    output DIN_READY, INSTRUCTION, INSTR_VALID, CPU_EN, LOAD_COUNT
  );
endinterface

// File: rtl/instr_fetch_loader.sv
// ---------------------------------------------------------------------------
// instr_fetch_loader
//   Instruction-supply stage for the cpu core. A program is streamed in
//   byte-serially over a valid/ready handshake into a small store; in run
//   mode the entry addressed by the core's PC is returned one cycle later on
//   a registered INSTRUCTION bus. Sequencing is IDLE -> LOAD -> RUN <-> HALT,
//   and CPU_EN lets the core advance only while a loaded program runs.
//
//   Parameters
//     DW     instruction width
//     DEPTH  store entries
//     AW     store address width, must equal log2(DEPTH)
//   Ports
//     CLK    clock, all state changes on the rising edge
//     RESET  synchronous reset, active-high; discards any program
//     bus    instr_fetch_loader_if.slave (load handshake + fetch bus)
// ---------------------------------------------------------------------------
module instr_fetch_loader #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input logic                  CLK,
  input logic                  RESET,
  instr_fetch_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  state_t        state;
  logic [DW-1:0] store [DEPTH];
  logic [AW:0]   load_count;
  logic [DW-1:0] instruction_q;
  logic          instr_valid_q;

  logic [AW-1:0] wptr;
  logic [AW-1:0] rd_addr;
  logic          rd_hit;
  logic          accept;
  logic          unused_pc_hi;

  // Bytes are written strictly in order, so the write pointer is simply the
  // low bits of the count; at FULL_COUNT it reads 0 but writes are blocked.
  assign wptr    = load_count[AW-1:0];

  // Upper PC bits are dropped, so fetch addresses wrap modulo DEPTH.
  assign rd_addr      = bus.PC[AW-1:0];
  assign unused_pc_hi = ^bus.PC[7:AW];
  assign rd_hit       = ({1'b0, rd_addr} < load_count);

  // Ready also drops with LOAD_EN, so the LOAD exit cycle never takes a byte.
  assign bus.DIN_READY = (state == LOAD) && bus.LOAD_EN && (load_count < FULL_COUNT);
  assign accept        = bus.DIN_VALID && bus.DIN_READY;

  assign bus.CPU_EN      = (state == RUN);
  assign bus.INSTRUCTION = instruction_q;
  assign bus.INSTR_VALID = instr_valid_q;
  assign bus.LOAD_COUNT  = load_count;

  // NOTE: all state here updates with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= IDLE;
      load_count    <= '0;
      instruction_q <= '0;
      instr_valid_q <= 1'b0;
      // NOTE: the store is a handful of flops, not a RAM macro, so clearing it
      // on reset is cheap and gives a known image after a discarded load.
      for (int i = 0; i < DEPTH; i++) begin
        store[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.LOAD_EN) begin
            state      <= LOAD;
            load_count <= '0;
          end
        end

        LOAD: begin
          if (!bus.LOAD_EN) begin
            state <= (load_count != '0) ? RUN : IDLE;
          end else if (accept) begin
            store[wptr] <= bus.DIN;
            load_count  <= load_count + 1'b1;
          end
        end

        RUN: begin
          if (bus.LOAD_EN) begin
            state         <= LOAD;
            load_count    <= '0;
            instr_valid_q <= 1'b0;
          end else if (bus.HALT_REQ) begin
            // Freeze on the halting edge: INSTRUCTION keeps the last fetch.
            state         <= HALT;
            instr_valid_q <= 1'b0;
          end else begin
            // Entries beyond the current program read as zero, never stale data.
            instruction_q <= rd_hit ? store[rd_addr] : '0;
            instr_valid_q <= rd_hit;
          end
        end

        HALT: begin
          if (bus.LOAD_EN) begin
            state      <= LOAD;
            load_count <= '0;
          end else if (!bus.HALT_REQ) begin
            state <= RUN;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
